// File: rtl/dram_traffic_gen_chk.sv
// Traffic generator and read-back checker for the DRAM controller: sweeps the
// rank/bank/row/column space with writes and reads and verifies returned data.
module dram_traffic_gen_chk #(
    parameter int DATA_W   = 128,
    parameter int NUM_RANK = 1,
    parameter int NUM_BANK = 1,
    parameter int NUM_ROW  = 32,
    parameter int NUM_COL  = 32,
    parameter int COL_STEP = 8,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              power_on_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       seed,
    input  logic [7:0]        ba_cmd_pm,
    output logic [33:0]       command,
    output logic              valid,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  read_count,
    output logic [CNT_W-1:0]  first_err_idx
);

    localparam int LANES = DATA_W / 32;
    localparam int N     = NUM_RANK * NUM_BANK * NUM_ROW * (NUM_COL / COL_STEP);
    localparam int IDX_W = $clog2(N + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] N_IDX     = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [9:0]       COL_INC   = 10'(COL_STEP);
    localparam logic [9:0]       COL_LAST  = 10'(NUM_COL - COL_STEP);
    localparam logic [12:0]      ROW_LAST  = 13'(NUM_ROW - 1);
    localparam logic [2:0]       BANK_LAST = 3'(NUM_BANK - 1);
    localparam logic [1:0]       RANK_LAST = 2'(NUM_RANK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [31:0]        seed_q, seed_d;
    logic               rw_q, rw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [9:0]         col_q, col_d, col_nx;
    logic [12:0]        row_q, row_d, row_nx;
    logic [2:0]         bank_q, bank_d, bank_nx;
    logic [1:0]         rank_q, rank_d, rank_nx;
    logic [IDX_W-1:0]   exp_idx_q, exp_idx_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic               err_seen_q, err_seen_d;
    logic               extra_q, extra_d;
    logic               timeout_q, timeout_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic               accept, last_idx, advance, rewind;

    // Lane j of the pattern for linear index n is seed ^ (n*LANES + j).
    function automatic logic [DATA_W-1:0] gen_data(input logic [31:0] s, input logic [31:0] n);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) begin
            d[j*32 +: 32] = s ^ (n * 32'(LANES) + 32'(j));
        end
        return d;
    endfunction

    assign valid      = (state_q == ISSUE);
    assign command    = valid ? {rank_q, rw_q, 1'b0, row_q, 1'b0, 1'b1, 1'b0, 1'b0, col_q, bank_q} : '0;
    assign write_data = (valid && !rw_q) ? gen_data(seed_q, 32'(idx_q)) : '0;
    assign accept     = valid && ba_cmd_pm[bank_q];
    assign last_idx   = (idx_q == LAST_IDX);

    assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign timeout       = timeout_q;
    assign error_count   = err_cnt_q;
    assign read_count    = rd_cnt_q;
    assign first_err_idx = first_err_q;
    assign pass          = done && (err_cnt_q == '0) && !timeout_q && (exp_idx_q == N_IDX) && !extra_q;

    // Next address: column fastest, then row, bank, rank.
    always_comb begin
        col_nx  = col_q + COL_INC;
        row_nx  = row_q;
        bank_nx = bank_q;
        rank_nx = rank_q;
        if (col_q == COL_LAST) begin
            col_nx = '0;
            if (row_q == ROW_LAST) begin
                row_nx = '0;
                if (bank_q == BANK_LAST) begin
                    bank_nx = '0;
                    rank_nx = (rank_q == RANK_LAST) ? 2'd0 : rank_q + 2'd1;
                end else begin
                    bank_nx = bank_q + 3'd1;
                end
            end else begin
                row_nx = row_q + 13'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        rw_d        = rw_q;
        idx_d       = idx_q;
        col_d       = col_q;
        row_d       = row_q;
        bank_d      = bank_q;
        rank_d      = rank_q;
        exp_idx_d   = exp_idx_q;
        err_cnt_d   = err_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        extra_d     = extra_q;
        timeout_d   = timeout_q;
        idle_d      = idle_q;
        advance     = 1'b0;
        rewind      = 1'b0;

        // Returns are checked independently of command acceptance in the same cycle.
        if (busy && read_data_valid) begin
            rd_cnt_d = (rd_cnt_q != CNT_MAX) ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
            if (exp_idx_q != N_IDX) begin
                if (read_data != gen_data(seed_q, 32'(exp_idx_q))) begin
                    err_cnt_d = (err_cnt_q != CNT_MAX) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
                    if (!err_seen_q) begin
                        err_seen_d  = 1'b1;
                        first_err_d = CNT_W'(exp_idx_q);
                    end
                end
                exp_idx_d = exp_idx_q + IDX_W'(1);
            end else begin
                extra_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ISSUE;
                    mode_d      = mode;
                    seed_d      = seed;
                    rw_d        = 1'b0;
                    rewind      = 1'b1;
                    exp_idx_d   = '0;
                    err_cnt_d   = '0;
                    rd_cnt_d    = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                    extra_d     = 1'b0;
                    timeout_d   = 1'b0;
                    idle_d      = '0;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (mode_q) begin
                        if (!rw_q) begin
                            rw_d = 1'b1;
                        end else begin
                            rw_d = 1'b0;
                            if (last_idx) begin
                                state_d = DRAIN;
                                idle_d  = '0;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end else if (!last_idx) begin
                        advance = 1'b1;
                    end else if (!rw_q) begin
                        rw_d   = 1'b1;
                        rewind = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        idle_d  = '0;
                    end
                end
            end
            DRAIN: begin
                if (exp_idx_q == N_IDX) begin
                    state_d = DONE;
                end else if (read_data_valid) begin
                    idle_d = '0;
                end else if (idle_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            idx_d  = idx_q + IDX_W'(1);
            col_d  = col_nx;
            row_d  = row_nx;
            bank_d = bank_nx;
            rank_d = rank_nx;
        end
        if (rewind) begin
            idx_d  = '0;
            col_d  = '0;
            row_d  = '0;
            bank_d = '0;
            rank_d = '0;
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            seed_q      <= '0;
            rw_q        <= 1'b0;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= '0;
            rank_q      <= '0;
            exp_idx_q   <= '0;
            err_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            extra_q     <= 1'b0;
            timeout_q   <= 1'b0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            rw_q        <= rw_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            rank_q      <= rank_d;
            exp_idx_q   <= exp_idx_d;
            err_cnt_q   <= err_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            extra_q     <= extra_d;
            timeout_q   <= timeout_d;
            idle_q      <= idle_d;
        end
    end

endmodule

// File: tb/tb_dram_traffic_gen_chk.sv
// Bench for dram_traffic_gen_chk: a memory model answers reads with random
// latency, and a command model built from the address/data rules checks every accept.
module tb_dram_traffic_gen_chk;

    localparam int DATA_W   = 128;
    localparam int NUM_RANK = 1;
    localparam int NUM_BANK = 2;
    localparam int NUM_ROW  = 2;
    localparam int NUM_COL  = 16;
    localparam int COL_STEP = 8;
    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 16;
    localparam int LANES    = DATA_W / 32;
    localparam int CG       = NUM_COL / COL_STEP;
    localparam int N        = NUM_RANK * NUM_BANK * NUM_ROW * CG;

    logic              clk = 1'b0;
    logic              power_on_rst_n;
    logic              start;
    logic              mode;
    logic [31:0]       seed;
    logic [7:0]        ba_cmd_pm;
    logic [33:0]       command;
    logic              valid;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              busy, done, pass, timeout;
    logic [CNT_W-1:0]  error_count, read_count, first_err_idx;

    dram_traffic_gen_chk #(
        .DATA_W(DATA_W), .NUM_RANK(NUM_RANK), .NUM_BANK(NUM_BANK), .NUM_ROW(NUM_ROW),
        .NUM_COL(NUM_COL), .COL_STEP(COL_STEP), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .power_on_rst_n(power_on_rst_n), .start(start), .mode(mode), .seed(seed),
        .ba_cmd_pm(ba_cmd_pm), .command(command), .valid(valid), .write_data(write_data),
        .read_data(read_data), .read_data_valid(read_data_valid), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .error_count(error_count), .read_count(read_count),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {logic [33:0] cmd; logic [DATA_W-1:0] wd;} exp_t;
    typedef struct {logic [DATA_W-1:0] d; int t;} ret_t;

    int vectors = 0;
    int miscompares = 0;

    exp_t              expq[$];
    ret_t              rq[$];
    logic [DATA_W-1:0] mem [int];

    int  bp_mode = 0;
    int  corrupt_beat = -1;
    bit  withhold = 1'b0;
    bit  extra_beat = 1'b0;
    bit  inject_req = 1'b0;
    bit  extra_pending = 1'b0;
    int  cyc = 0;
    int  beats = 0;
    int  last_t = 0;
    time last_acc_time = 0;
    time last_rdv_time = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model_cmd(input int n, input bit rw);
        int c, r, b, k;
        logic [9:0]  colv;
        logic [12:0] rowv;
        logic [2:0]  bankv;
        logic [1:0]  rankv;
        c = (n % CG) * COL_STEP;
        r = (n / CG) % NUM_ROW;
        b = (n / (CG * NUM_ROW)) % NUM_BANK;
        k = n / (CG * NUM_ROW * NUM_BANK);
        colv  = c[9:0];
        rowv  = r[12:0];
        bankv = b[2:0];
        rankv = k[1:0];
        return {rankv, rw, 1'b0, rowv, 1'b0, 1'b1, 1'b0, 1'b0, colv, bankv};
    endfunction

    function automatic logic [DATA_W-1:0] model_data(input logic [31:0] s, input int n);
        logic [DATA_W-1:0] d;
        logic [31:0] v;
        for (int j = 0; j < LANES; j++) begin
            v = 32'(n * LANES + j);
            d[j*32 +: 32] = s ^ v;
        end
        return d;
    endfunction

    // Memory/controller model: all inputs change on the falling edge, so the
    // accept decision made here matches what the DUT sees at the next rising edge.
    initial begin : responder
        ret_t r;
        exp_t e;
        int key;
        logic stall;
        logic [33:0] stall_cmd;
        logic [DATA_W-1:0] stall_wd;
        bit acc;
        stall = 1'b0;
        stall_cmd = '0;
        stall_wd = '0;
        ba_cmd_pm = 8'hFF;
        read_data_valid = 1'b0;
        read_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!power_on_rst_n) begin
                rq.delete();
                stall = 1'b0;
                extra_pending = 1'b0;
                read_data_valid = 1'b0;
                continue;
            end
            case (bp_mode)
                1:       ba_cmd_pm = {6'h3F, {2{((cyc / 3) % 2) == 0}}};
                2:       ba_cmd_pm = {6'h3F, 2'($urandom)};
                default: ba_cmd_pm = 8'hFF;
            endcase
            read_data_valid = 1'b0;
            read_data = {$urandom, $urandom, $urandom, $urandom};
            if (inject_req) begin
                read_data_valid = 1'b1;
                inject_req = 1'b0;
            end else if (extra_pending) begin
                read_data_valid = 1'b1;
                extra_pending = 1'b0;
                last_rdv_time = $time;
            end else if (rq.size() > 0 && rq[0].t <= cyc) begin
                r = rq.pop_front();
                if (!(withhold && beats == N - 1)) begin
                    read_data_valid = 1'b1;
                    read_data = r.d;
                    if (beats == corrupt_beat) read_data[5] = ~read_data[5];
                    last_rdv_time = $time;
                    if (extra_beat && beats == N - 1) extra_pending = 1'b1;
                end
                beats++;
            end
            if (stall && valid) begin
                checkOutput("cmd_stable", command, stall_cmd);
                checkOutput("wdata_stable", write_data, stall_wd);
            end
            if (valid) begin
                acc = ba_cmd_pm[command[2:0]];
                if (acc) begin
                    last_acc_time = $time;
                    checkOutput("cmd_expected", expq.size() != 0, 1'b1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        checkOutput("cmd", command, e.cmd);
                        checkOutput("wdata", write_data, e.wd);
                    end
                    key = int'({4'b0, command[33:32], command[2:0], command[29:17], command[12:3]});
                    if (!command[31]) begin
                        mem[key] = write_data;
                    end else begin
                        r.d = mem.exists(key) ? mem[key] : '0;
                        r.t = cyc + $urandom_range(1, 4);
                        if (r.t < last_t) r.t = last_t;
                        last_t = r.t;
                        rq.push_back(r);
                    end
                end
                stall = !acc;
                stall_cmd = command;
                stall_wd = write_data;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic startRun(input bit m, input logic [31:0] s, input int bp, input int cb,
                            input bit wh, input bit xb);
        exp_t e;
        @(negedge clk);
        bp_mode = bp;
        corrupt_beat = cb;
        withhold = wh;
        extra_beat = xb;
        beats = 0;
        last_t = 0;
        rq.delete();
        mem.delete();
        expq.delete();
        for (int n = 0; n < N; n++) begin
            e.cmd = model_cmd(n, 1'b0);
            e.wd = model_data(s, n);
            expq.push_back(e);
            if (m) begin
                e.cmd = model_cmd(n, 1'b1);
                e.wd = '0;
                expq.push_back(e);
            end
        end
        if (!m) begin
            for (int n = 0; n < N; n++) begin
                e.cmd = model_cmd(n, 1'b1);
                e.wd = '0;
                expq.push_back(e);
            end
        end
        start = 1'b1;
        mode = m;
        seed = s;
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        seed = ~s;
    endtask

    task automatic applyStimulus(input string name, input bit m, input logic [31:0] s, input int bp,
                                 input int cb, input bit wh, input bit xb, input bit restart);
        int  exp_rc, exp_ec, exp_fe;
        bit  exp_pass;
        time done_time, last_evt;
        $display("[TB] run %s mode=%0d seed=%h", name, m, s);
        startRun(m, s, bp, cb, wh, xb);
        if (restart) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        done_time = $time;
        exp_rc   = wh ? N - 1 : (xb ? N + 1 : N);
        exp_ec   = (cb >= 0) ? 1 : 0;
        exp_fe   = (cb >= 0) ? cb : 0;
        exp_pass = (cb < 0) && !wh && !xb;
        checkOutput({name, "_done"}, done, 1'b1);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_pass"}, pass, exp_pass);
        checkOutput({name, "_timeout"}, timeout, wh);
        checkOutput({name, "_error_count"}, error_count, CNT_W'(exp_ec));
        checkOutput({name, "_read_count"}, read_count, CNT_W'(exp_rc));
        checkOutput({name, "_first_err_idx"}, first_err_idx, CNT_W'(exp_fe));
        checkOutput({name, "_all_cmds_issued"}, expq.size(), 0);
        if (wh) begin
            last_evt = (last_acc_time > last_rdv_time) ? last_acc_time : last_rdv_time;
            checkOutput({name, "_timeout_latency"}, done_time - last_evt, (TIMEOUT + 1) * 10);
        end
        inject_req = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({name, "_rc_ignored_in_done"}, read_count, CNT_W'(exp_rc));
        checkOutput({name, "_ec_ignored_in_done"}, error_count, CNT_W'(exp_ec));
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_valid"}, valid, 1'b0);
        checkOutput({name, "_command"}, command, '0);
        checkOutput({name, "_write_data"}, write_data, '0);
        checkOutput({name, "_flags"}, {busy, done, pass, timeout}, 4'b0);
        checkOutput({name, "_counts"}, {error_count, read_count, first_err_idx}, '0);
    endtask

    initial begin : main
        power_on_rst_n = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        seed = '0;
        #1 power_on_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        #2 power_on_rst_n = 1'b1;

        applyStimulus("basic_m0", 1'b0, 32'h0, 0, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus("basic_m1", 1'b1, $urandom, 0, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus("bp_toggle_m0", 1'b0, $urandom, 1, -1, 1'b0, 1'b0, 1'b1);
        applyStimulus("bp_toggle_m1", 1'b1, $urandom, 1, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus("corrupt", 1'b0, 32'hA5A5A5A5, 0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus("timeout", 1'b1, $urandom, 2, -1, 1'b1, 1'b0, 1'b0);
        applyStimulus("extra_beat", 1'b0, $urandom, 0, -1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("random", 1'($urandom), $urandom, 2, -1, 1'b0, 1'b0, 1'b0);
        end

        startRun(1'b0, $urandom, 0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (valid && command === model_cmd(2, 1'b0)) break;
            @(negedge clk);
        end
        checkOutput("reached_write2", {valid, command}, {1'b1, model_cmd(2, 1'b0)});
        #2 power_on_rst_n = 1'b0;
        #1 checkResetState("midrun_reset");
        repeat (2) @(negedge clk);
        #2 power_on_rst_n = 1'b1;
        applyStimulus("after_reset", 1'b1, $urandom, 2, -1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_traffic_gen_chk.md
Name: dram_traffic_gen_chk

Overview:
Synthesizable, parametrised traffic generator and read-back checker for the DRAM memory controller. It sweeps a configurable rank/bank/row/column space and issues write and read commands in the controller's 34-bit command format. Each command is gated by the per-bank ready vector. Returned read data is compared against regenerated expected data, and the block reports error and read counts plus a pass/fail verdict. It replaces the behavioural write-all/read-all bench stimulus and adds an interleaved mode, seeded data, and a drain timeout.

Parameters:
DATA_W, 128, write/read data width; a multiple of 32.
NUM_RANK, 1, ranks swept (1..4).
NUM_BANK, 1, banks swept (1..8).
NUM_ROW, 32, rows swept (<= 2^13).
NUM_COL, 32, columns swept (<= 2^10); a multiple of COL_STEP.
COL_STEP, 8, column increment per command (BL8).
CNT_W, 16, width of the counters and error_count.
TIMEOUT, 4096, idle cycles allowed in DRAIN before aborting.

Ports:
clk  in  1  system clock
power_on_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when in IDLE
mode  in  1  0 = write-all then read-all; 1 = write/read interleaved per address
seed  in  32  data seed; latched on start
ba_cmd_pm  in  8  per-bank command-ready from controller
command  out  34  {rank[1:0], rw, 1'b0, row[12:0], 1'b0, bl=1, 1'b0, auto_pre=0, col[9:0], bank[2:0]}; rw: 0 = write, 1 = read
valid  out  1  command/write_data valid
write_data  out  DATA_W  data for a write command
read_data  in  DATA_W  returned read data
read_data_valid  in  1  read_data qualifier; returns are in-order
busy  out  1  high from start until done
done  out  1  sticky; high in DONE state
pass  out  1  valid when done: error_count==0 && !timeout && read_count==N
timeout  out  1  sticky; drain timeout occurred
error_count  out  CNT_W  mismatching beats; saturating
read_count  out  CNT_W  read beats received; saturating
first_err_idx  out  CNT_W  linear index of first mismatch

Behaviour:
- Reset: all outputs 0; FSM = IDLE; all counters and indices 0.
- Address space: N = NUM_RANK*NUM_BANK*NUM_ROW*(NUM_COL/COL_STEP). Linear index n maps column fastest, then row, bank, rank; col = (n mod (NUM_COL/COL_STEP))*COL_STEP.
- Data rule: 32-bit lane j of the data for index n = seed ^ (n*(DATA_W/32) + j), truncated to 32 bits. The checker regenerates the same value from its own expected-index counter.
- Handshake: a command is accepted on a posedge where valid==1 && ba_cmd_pm[command[2:0]]==1. While valid is high, command and write_data stay stable until accepted. The next command may be presented the cycle after acceptance, giving one command per cycle peak. write_data is 0 for reads.
- FSM:
  - IDLE: waits for start; latches seed and mode; clears counters, done, timeout. start outside IDLE is ignored.
  - ISSUE:
    - mode 0: issues writes n = 0..N-1, then reads n = 0..N-1.
    - mode 1: for each n, issues the write then the read of n.
    - After the last read is accepted, goes to DRAIN.
  - DRAIN: waits until read_count == N, then goes to DONE. If TIMEOUT consecutive cycles pass with no read_data_valid, sets timeout and goes to DONE.
  - DONE: done = 1, busy = 0; pass is evaluated. Holds until the next start, which returns the block through IDLE behaviour.
- Checker: on every read_data_valid, compares read_data with the expected data for exp_idx, then increments exp_idx. On mismatch, increments error_count; on the first mismatch, also captures exp_idx into first_err_idx.
- Checker timing: the checker is active in ISSUE and DRAIN. A read_data_valid in IDLE or DONE is ignored. A read_data_valid beyond N is counted in read_count, not compared, and forces pass = 0.
- Simultaneous events: acceptance and read_data_valid in the same cycle are handled independently.
- Counters saturate at all ones.
- Reset mid-run: returns immediately to the reset state and drops valid asynchronously. No partial command is retained.

Test Plan:
- Basic mode 0 (NUM_ROW=2, NUM_COL=16, ba_cmd_pm=8'hFF, seed=0, ideal memory model): expect 4 writes (row 0 col 0, row 0 col 8, row 1 col 0, row 1 col 8), then 4 reads in the same order. Required result: done=1, pass=1, read_count=4, error_count=0.
- Mode 1 (same config): the command stream alternates W0, R0, W1, R1, … with rw bits 0,1,0,1. Required result: pass=1.
- Backpressure: toggle ba_cmd_pm[0] every 3 cycles. command and write_data must be stable while valid && !ready, and there must be no duplicate or skipped indices. Required result: pass=1.
- Corrupted return: flip bit 5 of the 3rd returned beat (seed=32'hA5A5A5A5). Required result: error_count=1, first_err_idx=2, pass=0.
- Timeout (TIMEOUT=16): the model withholds the last read. Required result: timeout=1 after 16 idle cycles in DRAIN, done=1, pass=0, read_count=N-1.
- Reset mid-run: assert power_on_rst_n=0 during write index 2. Required result: valid=0 immediately and all outputs 0. A new start then completes the run with pass=1.
